// File: rtl/conv_frame_scheduler_pkg.sv
// Shared definitions for the convolution frame scheduler: FSM state
// encoding, error-flag bit positions and the core clear length.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Bit positions inside the sticky err vector
    localparam int ERR_CFG  = 0;
    localparam int ERR_TMO  = 1;
    localparam int ERR_BITS = 2;

    // Number of cycles the core is held in reset between frames
    localparam int CLEAR_CYCLES = 2;

endpackage

// File: rtl/conv_frame_scheduler_raster_pos_tracker.sv
// Follows the raster position of each core result. The core only produces
// results once K-1 full rows have been seen, so the row starts at K-1.
// A result is interior when its window lies completely inside the frame.
module raster_pos_tracker #(
    parameter int KERNEL_SIZE = 3,
    parameter int MAX_WIDTH   = 64,
    parameter int MAX_HEIGHT  = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear_i,
    input  logic                               advance_i,
    input  logic [$clog2(MAX_WIDTH + 1)-1:0]   width_i,
    output logic                               interior_o
);

    localparam int CW = $clog2(MAX_WIDTH + 1);
    localparam int RW = $clog2(MAX_HEIGHT + 1);
    localparam logic [CW-1:0] KM1_CW    = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_START = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Next position: clear restarts at (K-1, 0), each result steps one column
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = ROW_START;
        end else if (advance_i) begin
            if (col_q == width_i - CW'(1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= ROW_START;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Left K-1 columns are border; rows below K-1 never reach us from the core
    assign interior_o = (col_q >= KM1_CW) && (row_q >= ROW_START);

endmodule

// File: rtl/conv_frame_scheduler.sv
// Frame sequencer for the streaming KxK convolution core: validates the
// frame size, clears the core, feeds the raster stream through, forwards
// only interior results and reports completion, config errors and timeouts.
module conv_frame_scheduler
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int KERNEL_SIZE   = 3,
    parameter int MAX_WIDTH     = 64,
    parameter int MAX_HEIGHT    = 64,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic [$clog2(MAX_WIDTH + 1)-1:0]    cfg_width,
    input  logic [$clog2(MAX_HEIGHT + 1)-1:0]   cfg_height,
    input  logic [DATA_WIDTH-1:0]               s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [DATA_WIDTH-1:0]               core_pixel,
    output logic                                core_valid,
    output logic                                core_rst_n,
    input  logic [DATA_WIDTH-1:0]               core_out,
    input  logic                                core_valid_out,
    output logic [DATA_WIDTH-1:0]               m_data,
    output logic                                m_valid,
    output logic                                busy,
    output logic                                done,
    output logic [ERR_BITS-1:0]                 err
);

    localparam int CW = $clog2(MAX_WIDTH + 1);
    localparam int RW = $clog2(MAX_HEIGHT + 1);
    localparam int NW = $clog2(MAX_WIDTH * MAX_HEIGHT + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int LW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [CW-1:0] K_CW     = CW'(KERNEL_SIZE);
    localparam logic [RW-1:0] K_RW     = RW'(KERNEL_SIZE);
    localparam logic [CW-1:0] KM1_CW   = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] KM1_RW   = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] MAXW_CW  = CW'(MAX_WIDTH);
    localparam logic [RW-1:0] MAXH_RW  = RW'(MAX_HEIGHT);
    localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [LW-1:0] CLR_LAST = LW'(CLEAR_CYCLES - 1);

    state_e                 state_q;
    logic [CW-1:0]          w_q;
    logic [RW-1:0]          h_q;
    logic [NW-1:0]          in_cnt_q, in_cnt_d;
    logic [NW-1:0]          acc_cnt_q, acc_cnt_d;
    logic [TW-1:0]          tmo_cnt_q;
    logic [LW-1:0]          clr_cnt_q;
    logic                   abort_pend_q;
    logic                   s_ready_q;
    logic [DATA_WIDTH-1:0]  core_pixel_q;
    logic                   core_valid_q;
    logic                   core_rst_n_q;
    logic [DATA_WIDTH-1:0]  m_data_q;
    logic                   m_valid_q;
    logic                   done_q;
    logic [ERR_BITS-1:0]    err_q;

    logic [NW-1:0]          frame_px;
    logic [NW-1:0]          frame_res;
    logic                   cfg_ok;
    logic                   xfer;
    logic                   abort_hit;
    logic                   interior;
    logic                   fwd;

    raster_pos_tracker #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .MAX_WIDTH   (MAX_WIDTH),
        .MAX_HEIGHT  (MAX_HEIGHT)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (state_q == ST_CLEAR),
        .advance_i  (core_valid_out),
        .width_i    (w_q),
        .interior_o (interior)
    );

    // Frame sizes and event qualifiers derived from the current registers
    always_comb begin
        frame_px  = NW'(w_q) * NW'(h_q);
        frame_res = NW'(w_q - KM1_CW) * NW'(h_q - KM1_RW);
        in_cnt_d  = in_cnt_q + NW'(1);
        acc_cnt_d = acc_cnt_q + NW'(1);
        cfg_ok    = (cfg_width >= K_CW) && (cfg_width <= MAXW_CW) &&
                    (cfg_height >= K_RW) && (cfg_height <= MAXH_RW);
        xfer      = s_valid && s_ready_q;
        abort_hit = abort && (state_q != ST_IDLE);
        // A result that coincides with abort is dropped
        fwd       = core_valid_out && interior && !abort_hit &&
                    ((state_q == ST_STREAM) || (state_q == ST_DRAIN));
    end

    // Frame FSM with all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            in_cnt_q     <= '0;
            acc_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            clr_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            s_ready_q    <= 1'b0;
            core_pixel_q <= '0;
            core_valid_q <= 1'b0;
            core_rst_n_q <= 1'b1;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            core_valid_q <= 1'b0;
            done_q       <= 1'b0;
            m_valid_q    <= fwd;
            if (fwd) begin
                m_data_q <= core_out;
            end
            // Any core activity restarts the drain watchdog
            if (core_valid_out) begin
                tmo_cnt_q <= '0;
            end

            if (abort_hit) begin
                state_q      <= ST_CLEAR;
                abort_pend_q <= 1'b1;
                clr_cnt_q    <= '0;
                core_rst_n_q <= 1'b0;
                s_ready_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                w_q          <= cfg_width;
                                h_q          <= cfg_height;
                                err_q        <= '0;
                                abort_pend_q <= 1'b0;
                                clr_cnt_q    <= '0;
                                core_rst_n_q <= 1'b0;
                                state_q      <= ST_CLEAR;
                            end else begin
                                err_q[ERR_CFG] <= 1'b1;
                            end
                        end
                    end

                    ST_CLEAR: begin
                        in_cnt_q  <= '0;
                        acc_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                        if (clr_cnt_q == CLR_LAST) begin
                            core_rst_n_q <= 1'b1;
                            if (abort_pend_q) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q   <= ST_STREAM;
                                s_ready_q <= 1'b1;
                            end
                        end else begin
                            clr_cnt_q <= clr_cnt_q + LW'(1);
                        end
                    end

                    ST_STREAM: begin
                        if (xfer) begin
                            core_pixel_q <= s_data;
                            core_valid_q <= 1'b1;
                            in_cnt_q     <= in_cnt_d;
                            if (in_cnt_d == frame_px) begin
                                s_ready_q <= 1'b0;
                                state_q   <= ST_DRAIN;
                            end
                        end
                        // Completion can overtake the input side
                        if (fwd) begin
                            acc_cnt_q <= acc_cnt_d;
                            if (acc_cnt_d == frame_res) begin
                                s_ready_q <= 1'b0;
                                done_q    <= 1'b1;
                                state_q   <= ST_DONE;
                            end
                        end
                    end

                    ST_DRAIN: begin
                        if (fwd) begin
                            acc_cnt_q <= acc_cnt_d;
                            if (acc_cnt_d == frame_res) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end else if (!core_valid_out) begin
                            if (tmo_cnt_q == TMO_LAST) begin
                                err_q[ERR_TMO] <= 1'b1;
                                done_q         <= 1'b1;
                                state_q        <= ST_DONE;
                            end else begin
                                tmo_cnt_q <= tmo_cnt_q + TW'(1);
                            end
                        end
                    end

                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign core_pixel = core_pixel_q;
    assign core_valid = core_valid_q;
    assign core_rst_n = core_rst_n_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Bench for conv_frame_scheduler: an echo core model, a raster-rule model of
// which results are interior, and a per-cycle result comparator.
module tb_conv_frame_scheduler;

    localparam int K = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] cfg_width = '0;
    logic [6:0] cfg_height = '0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] core_pixel;
    logic       core_valid;
    logic       core_rst_n;
    logic [7:0] core_out;
    logic       core_valid_out;
    logic [7:0] m_data;
    logic       m_valid;
    logic       busy;
    logic       done;
    logic [1:0] err;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame bookkeeping shared between driver and monitor
    int cur_w = 4;
    int resp_limit = 1000;
    int frame_total = 0;
    int xfer_seen = 0;
    int done_cnt = 0;
    int rst_low_cnt = 0;
    int tail_cycles = 0;
    int ready_after_last = 0;
    int m_cnt = 0;
    int exp_v;
    int exp_q[$];
    int got_q[$];

    // Core model state
    int core_cnt;
    int core_emit;

    always #5 clk = ~clk;

    conv_frame_scheduler #(
        .DATA_WIDTH    (8),
        .KERNEL_SIZE   (3),
        .MAX_WIDTH     (64),
        .MAX_HEIGHT    (64),
        .DRAIN_TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .core_pixel     (core_pixel),
        .core_valid     (core_valid),
        .core_rst_n     (core_rst_n),
        .core_out       (core_out),
        .core_valid_out (core_valid_out),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Echo core: one result per pixel once K-1 rows are buffered, 1-cycle latency,
    // optionally going silent after resp_limit results
    always @(posedge clk) begin
        if (!rst_n || !core_rst_n) begin
            core_cnt       <= 0;
            core_emit      <= 0;
            core_valid_out <= 1'b0;
            core_out       <= '0;
        end else begin
            core_valid_out <= 1'b0;
            if (core_valid) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt >= (K - 1) * cur_w && core_emit < resp_limit) begin
                    core_valid_out <= 1'b1;
                    core_out       <= core_pixel;
                    core_emit      <= core_emit + 1;
                end
            end
        end
    end

    // Monitor and result comparator, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !done && frame_total > 0 && xfer_seen == frame_total) tail_cycles++;
            if (s_ready && xfer_seen >= frame_total) ready_after_last++;
            if (s_valid && s_ready) xfer_seen++;
            if (done) done_cnt++;
            if (!core_rst_n) rst_low_cnt++;
            if (m_valid) begin
                m_cnt++;
                got_q.push_back(int'(m_data));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL m_extra: got m_data=%0d, required no result", m_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    $display("t=%0t result m_data=%0d expected=%0d", $time, m_data, exp_v);
                    check("m_data", int'(m_data), exp_v);
                end
            end
        end
    end

    // One frame: start, stream pixels (optionally gapped), then either wait for
    // done or abort after abort_after transfers
    task automatic run_frame(input int w, input int h, input bit gap, input int resp_lim,
                             input int abort_after, input int exp_err, input int exp_tail);
        int idx;
        int cyc;
        int busy_low;
        int exp_n;
        int total;
        total = w * h;
        cur_w = w;
        resp_limit = resp_lim;
        exp_q.delete();
        got_q.delete();
        // Interior rule: row >= K-1 and col >= K-1, limited to what the core emits
        for (int i = 0; i < total; i++) begin
            if (abort_after < 0 && i >= (K - 1) * w && (i - (K - 1) * w) < resp_lim &&
                (i % w) >= K - 1)
                exp_q.push_back(i + 1);
        end
        exp_n = exp_q.size();
        frame_total = total;
        xfer_seen = 0;
        done_cnt = 0;
        rst_low_cnt = 0;
        tail_cycles = 0;
        ready_after_last = 0;
        m_cnt = 0;

        @(posedge clk); #1;
        start = 1'b1;
        cfg_width = 7'(w);
        cfg_height = 7'(h);
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0;
        cyc = 0;
        busy_low = 0;
        while (cyc < 400) begin
            if (abort_after >= 0 && idx == abort_after) break;
            s_valid = (idx < total) && (!gap || (cyc % 2 == 0));
            s_data = 8'(idx + 1);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            if (!busy) busy_low++;
            if (done) break;
            @(posedge clk); #1;
            cyc++;
        end

        if (abort_after >= 0) begin
            s_valid = 1'b0;
            abort = 1'b1;
            rst_low_cnt = 0;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("s_ready_after_abort", int'(s_ready), 0);
            for (int i = 0; i < 20; i++) begin
                if (!busy) break;
                @(negedge clk);
            end
            repeat (5) @(negedge clk);
            $display("frame %0dx%0d aborted after %0d transfers, err=%0d", w, h, xfer_seen, err);
            check("abort_transfers", xfer_seen, abort_after);
            check("abort_idle", int'(busy), 0);
            check("abort_clear_cycles", rst_low_cnt, 2);
            check("abort_done", done_cnt, 0);
            check("abort_outputs", m_cnt, 0);
            check("abort_err", int'(err), exp_err);
        end else begin
            s_valid = 1'b0;
            check("done_reached", int'(done), 1);
            repeat (5) @(negedge clk);
            $display("frame %0dx%0d: %0d transfers, %0d results, done=%0d, err=%0d, tail=%0d",
                     w, h, xfer_seen, m_cnt, done_cnt, err, tail_cycles);
            check("done_pulses", done_cnt, 1);
            check("err", int'(err), exp_err);
            check("clear_cycles", rst_low_cnt, 2);
            check("transfers", xfer_seen, total);
            check("ready_after_last", ready_after_last, 0);
            check("tail_cycles", tail_cycles, exp_tail);
            check("busy_drop", busy_low, 0);
            check("out_count", m_cnt, exp_n);
            check("missing_results", exp_q.size(), 0);
            check("idle_after", int'(busy), 0);
        end
    endtask

    task automatic cfg_err_case(input int w, input int h);
        int busy_hi;
        busy_hi = 0;
        done_cnt = 0;
        rst_low_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_width = 7'(w);
        cfg_height = 7'(h);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        $display("start %0dx%0d rejected: err=%0d busy_cycles=%0d", w, h, err, busy_hi);
        check("cfg_err", int'(err), 1);
        check("cfg_busy", busy_hi, 0);
        check("cfg_clear", rst_low_cnt, 0);
        check("cfg_done", done_cnt, 0);
    endtask

    task automatic check_got(input string name, input int idx, input int req);
        check(name, (idx < got_q.size()) ? got_q[idx] : -1, req);
    endtask

    initial begin
        int lit4[4];
        int lit3[3];
        lit4 = '{11, 12, 15, 16};
        lit3 = '{13, 14, 15};

        repeat (3) @(negedge clk);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_core_valid", int'(core_valid), 0);
        check("rst_core_pixel", int'(core_pixel), 0);
        check("rst_core_rst_n", int'(core_rst_n), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 4x4, continuous stream
        run_frame(4, 4, 1'b0, 1000, -1, 0, 2);
        for (int i = 0; i < 4; i++) check_got("lit_4x4", i, lit4[i]);

        // 4x4, source valid every other cycle
        run_frame(4, 4, 1'b1, 1000, -1, 0, 2);
        for (int i = 0; i < 4; i++) check_got("lit_4x4_gap", i, lit4[i]);

        // Rejected sizes
        cfg_err_case(2, 4);
        cfg_err_case(4, 65);

        // Core goes silent after two results: drain watchdog
        run_frame(4, 4, 1'b0, 2, -1, 2, 64);

        // Abort after 7 transfers
        run_frame(4, 4, 1'b0, 1000, 7, 0, 0);

        // Back-to-back frames of different shape
        run_frame(4, 4, 1'b0, 1000, -1, 0, 2);
        for (int i = 0; i < 4; i++) check_got("lit_b2b_4x4", i, lit4[i]);
        run_frame(5, 3, 1'b0, 1000, -1, 0, 2);
        for (int i = 0; i < 3; i++) check_got("lit_5x3", i, lit3[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_frame_scheduler.md
Name: conv_frame_scheduler

Overview:
Frame-level sequencer for the streaming 3x3 convolution core. It accepts a raster pixel stream from an upstream source over a valid/ready handshake, clears the core between frames, and feeds pixels to the core. It tracks the raster position of each core result and forwards only the interior results, those whose full window lies inside the frame. It reports frame completion, configuration errors and drain timeouts.

Parameters:
DATA_WIDTH, 8, pixel and result width
KERNEL_SIZE, 3, kernel edge K; sets warm-up rows and border columns
MAX_WIDTH, 64, largest supported frame width
MAX_HEIGHT, 64, largest supported frame height
DRAIN_TIMEOUT, 64, maximum idle cycles without a core result while in DRAIN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start request, honoured only in IDLE
abort  in  1  cancel the current frame; priority over all events except reset
cfg_width  in  CW=$clog2(MAX_WIDTH+1)  frame width W, sampled on accepted start
cfg_height  in  RW=$clog2(MAX_HEIGHT+1)  frame height H, sampled on accepted start
s_data  in  DATA_WIDTH  source pixel
s_valid  in  1  source pixel valid
s_ready  out  1  scheduler accepts a pixel
core_pixel  out  DATA_WIDTH  to core pixel_in
core_valid  out  1  to core valid_in
core_rst_n  out  1  registered, active-low clear to the core reset
core_out  in  DATA_WIDTH  core result
core_valid_out  in  1  core result valid
m_data  out  DATA_WIDTH  interior result
m_valid  out  1  interior result valid; no backpressure
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on frame completion
err  out  2  sticky until the next accepted start: bit0 cfg_err, bit1 timeout

Behaviour:
- Reset values: s_ready=0, core_valid=0, core_pixel=0, core_rst_n=1, m_valid=0, m_data=0, busy=0, done=0, err=0, state=IDLE, all counters 0.
- States are IDLE, CLEAR, STREAM, DRAIN and DONE.
- IDLE:
  - On start, if K<=W<=MAX_WIDTH and K<=H<=MAX_HEIGHT: latch W and H, clear err, go to CLEAR.
  - Otherwise set err[0] and stay in IDLE; done is not asserted.
- CLEAR:
  - core_rst_n=0 for exactly 2 cycles, then core_rst_n=1 and go to STREAM.
  - Input and output counters are zeroed on entry.
- STREAM:
  - s_ready=1 while in_cnt < W*H.
  - On s_valid&&s_ready, register the pixel: core_pixel and core_valid are updated on the next edge, giving 1-cycle latency. core_valid=0 in cycles with no transfer.
  - After the W*H-th transfer, s_ready drops in the same cycle as that transfer is registered, and the FSM goes to DRAIN.
  - Source gaps (s_valid=0) are legal and simply delay progress.
- Core contract:
  - The core emits one core_valid_out per input pixel with raster index >= (K-1)*W, in raster order.
  - The scheduler tracks out_row (starting at K-1) and out_col (0..W-1, wrapping to 0 with out_row++) on every core_valid_out, in any state.
- Result gating:
  - m_valid is registered: m_valid=core_valid_out && out_col>=K-1, with m_data=core_out, 1-cycle latency.
  - Border results are dropped silently.
- Completion and timeout:
  - acc_cnt counts forwarded interior results.
  - When acc_cnt reaches (H-K+1)*(W-K+1), go to DONE; this may occur in STREAM or DRAIN.
  - A timeout counter resets on every core_valid_out. In DRAIN, reaching DRAIN_TIMEOUT sets err[1] and goes to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- abort:
  - From any non-IDLE state, go to CLEAR, then IDLE instead of STREAM.
  - s_ready and m_valid drop the next cycle. No done is issued; err is unchanged.
- Simultaneous events:
  - start in a non-IDLE state is ignored.
  - abort and the completing result in the same cycle: abort wins and the result is not forwarded.
- Widths: in_cnt and acc_cnt are $clog2(MAX_WIDTH*MAX_HEIGHT+1) bits; products are computed at this width.

Decomposition:
- Shared package conv_pkg holds:
  - the state encoding: IDLE=0, CLEAR=1, STREAM=2, DRAIN=3, DONE=4, 3 bits;
  - the err bit indices;
  - the CLEAR_CYCLES=2 constant.
- One sub-module, raster_pos_tracker, owns out_row/out_col, the wrap logic and the interior flag. It has clear and advance inputs and an interior output.

Test Plan:
- K=3, W=H=4, pixels 1..16 with no gaps, core model that echoes its input -> 16 transfers, m_valid exactly 4 times with m_data=11,12,15,16, then done pulse, err=0.
- s_valid toggled every other cycle on the same 4x4 frame -> same 4 outputs, s_ready never high after the 16th transfer, busy held throughout.
- start with cfg_width=2 -> err=01, stays IDLE, no core_rst_n pulse, no done, busy=0.
- Core model stops responding after 2 results -> DRAIN lasts 64 cycles, err=10, single done pulse, return to IDLE.
- abort after 7 transfers -> s_ready=0 next cycle, core_rst_n low for 2 cycles, IDLE, no done.
- Two back-to-back frames (4x4 then 5x3) -> core_rst_n pulse before each; second frame yields 3 outputs, one done per frame.
